ldl_fifo_rs_v1: RTL and testbench

Read-side controller of the LDL synchronous FIFO. It pairs with the write-side controller and a simple dual-port RAM that has a 1-cycle synchronous read. It owns the read pointer, generates RAM read address and enable, and derives empty and count from the write-side pointer. With AHEAD=1 it prefetches into a 2-entry output buffer, so the head word is presented before the read (show-ahead) at full one-word-per-cycle throughput.

---
 rtl/ldl_fifo_rs_v1_if.sv | 27 ++
 rtl/ldl_fifo_rs_v1.sv | 104 ++++++++++
 tb/tb_ldl_fifo_rs_v1.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldl_fifo_rs_v1_if.sv
// Read-side bundle of the LDL FIFO: user read port, RAM read port and pointer exchange.
// master = read-side controller, slave = user/RAM/write-side environment.
interface ldl_fifo_rs_v1_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          re;
    logic          empty;
    logic [AW-1:0] ra;
    logic [AW:0]   w_pt;
    logic [AW:0]   r_pt;
    logic          mr;
    logic [DW-1:0] rd;
    logic [DW-1:0] q;
    logic          qv;
    logic [AW+1:0] rcnt;

    modport master (
        input  re, w_pt, rd,
        output empty, ra, r_pt, mr, q, qv, rcnt
    );

    modport slave (
        output re, w_pt, rd,
        input  empty, ra, r_pt, mr, q, qv, rcnt
    );
endinterface

// File: rtl/ldl_fifo_rs_v1.sv
// LDL FIFO read-side controller: owns the read pointer and RAM read port, derives empty/count,
// and in show-ahead mode prefetches into a 2-entry output buffer for bubble-free reads.
module ldl_fifo_rs_v1 #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned AHEAD = 1
) (
    input  logic                clk,
    input  logic                rst,
    ldl_fifo_rs_v1_if.master    io_rs
);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = AW + 2;

    logic [AW:0] r_pt;
    logic        w_mne;
    logic        w_mr;
    logic [AW:0] w_diff;

    assign w_mne       = (io_rs.w_pt != r_pt);
    assign w_diff      = io_rs.w_pt - r_pt;
    assign io_rs.r_pt  = r_pt;
    assign io_rs.ra    = r_pt[AW-1:0];
    assign io_rs.mr    = w_mr;

    // Read pointer advances on every RAM read; wrap bit toggles on natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pt <= '0;
        end else if (w_mr) begin
            r_pt <= r_pt + PW'(1);
        end
    end

    generate
        if (AHEAD == 0) begin : g_norm
            logic r_qv;

            assign w_mr       = io_rs.re & w_mne;
            assign io_rs.empty = ~w_mne;
            assign io_rs.q    = io_rs.rd;
            assign io_rs.qv   = r_qv;
            assign io_rs.rcnt = CW'(w_diff);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_qv <= 1'b0;
                end else begin
                    r_qv <= w_mr;
                end
            end
        end else begin : g_ahead
            logic [1:0]    r_occ;
            logic          r_pend;
            logic [DW-1:0] r_q0;
            logic [DW-1:0] r_q1;
            logic          w_pop;
            logic [1:0]    w_occ_nxt;
            logic [1:0]    w_base;
            logic [DW-1:0] w_q0_nxt;
            logic [DW-1:0] w_q1_nxt;

            // pend=1 implies occ<=1, so occ+pend never exceeds 2 and fits two bits.
            assign w_pop      = io_rs.re & (r_occ != 2'd0);
            assign w_occ_nxt  = r_occ + 2'(r_pend) - 2'(w_pop);
            assign w_base     = r_occ - 2'(w_pop);
            assign w_mr       = w_mne & (w_occ_nxt < 2'd2);

            assign io_rs.empty = (r_occ == 2'd0);
            assign io_rs.qv   = (r_occ != 2'd0);
            assign io_rs.q    = r_q0;
            assign io_rs.rcnt = CW'(w_diff) + CW'(r_occ) + CW'(r_pend);

            // Pop shifts skid into head; landing data fills the lowest free entry after the pop.
            always_comb begin
                w_q0_nxt = r_q0;
                w_q1_nxt = r_q1;
                if (w_pop) begin
                    w_q0_nxt = r_q1;
                end
                if (r_pend && (w_base == 2'd0)) begin
                    w_q0_nxt = io_rs.rd;
                end
                if (r_pend && (w_base == 2'd1)) begin
                    w_q1_nxt = io_rs.rd;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_occ  <= 2'd0;
                    r_pend <= 1'b0;
                    r_q0   <= '0;
                    r_q1   <= '0;
                end else begin
                    r_occ  <= w_occ_nxt;
                    r_pend <= w_mr;
                    r_q0   <= w_q0_nxt;
                    r_q1   <= w_q1_nxt;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_ldl_fifo_rs_v1.sv
// Bench for ldl_fifo_rs_v1: show-ahead and normal instances, each with a RAM and write-side model.
module tb_ldl_fifo_rs_v1;
    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;
    localparam int unsigned NV = 14;

    typedef struct {
        bit         sel;
        bit         we;
        logic [7:0] wd;
        bit         re;
        bit         e_empty;
        bit         e_qv;
        logic [7:0] e_q;
        logic [4:0] e_rcnt;
        logic [3:0] e_rpt;
        bit         e_mr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       we1, we0;
    logic [7:0] wd1, wd0;
    logic [7:0] mem1 [8];
    logic [7:0] mem0 [8];
    int         n_checks = 0;
    int         n_errors = 0;
    int         mr_viol  = 0;
    vec_t       tbl [NV];

    always #5 clk = ~clk;

    ldl_fifo_rs_v1_if #(.AW(AW), .DW(DW)) if1 ();
    ldl_fifo_rs_v1_if #(.AW(AW), .DW(DW)) if0 ();

    ldl_fifo_rs_v1 #(.AW(AW), .DW(DW), .AHEAD(1)) u_a1 (.clk(clk), .rst(rst), .io_rs(if1));
    ldl_fifo_rs_v1 #(.AW(AW), .DW(DW), .AHEAD(0)) u_a0 (.clk(clk), .rst(rst), .io_rs(if0));

    // Write side and 1-cycle synchronous-read RAM for each instance.
    always_ff @(posedge clk) begin
        if (rst) begin
            if1.w_pt <= '0;
            if0.w_pt <= '0;
        end else begin
            if (we1) begin
                mem1[if1.w_pt[2:0]] <= wd1;
                if1.w_pt <= if1.w_pt + 4'd1;
            end
            if (we0) begin
                mem0[if0.w_pt[2:0]] <= wd0;
                if0.w_pt <= if0.w_pt + 4'd1;
            end
        end
        if (if1.mr) if1.rd <= mem1[if1.ra];
        if (if0.mr) if0.rd <= mem0[if0.ra];
    end

    // RAM must never be read with nothing in it.
    always @(negedge clk) begin
        if (!rst && ((if1.mr && (if1.w_pt == if1.r_pt)) || (if0.mr && (if0.w_pt == if0.r_pt))))
            mr_viol <= mr_viol + 1;
    end

    function automatic vec_t mk(bit sel, bit we, logic [7:0] wd, bit re, bit e_empty, bit e_qv,
                                logic [7:0] e_q, logic [4:0] e_rcnt, logic [3:0] e_rpt, bit e_mr);
        vec_t v;
        v.sel = sel; v.we = we; v.wd = wd; v.re = re;
        v.e_empty = e_empty; v.e_qv = e_qv; v.e_q = e_q;
        v.e_rcnt = e_rcnt; v.e_rpt = e_rpt; v.e_mr = e_mr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        we1 = 1'b0; we0 = 1'b0; wd1 = 8'h00; wd0 = 8'h00;
        if1.re = 1'b0; if0.re = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] d0, d1;
        logic [7:0] exp_q;
        bit         re;
        int         wi0, wi1, ri0, ri1;

        rst = 1'b1;
        clear_in();

        // show-ahead: single word 0xA5, then pop it
        tbl[0]  = mk(1, 1, 8'hA5, 0,  1, 0, 8'h00, 5'd0, 4'd0, 0);
        tbl[1]  = mk(1, 0, 8'h00, 0,  1, 0, 8'h00, 5'd1, 4'd0, 1);
        tbl[2]  = mk(1, 0, 8'h00, 0,  1, 0, 8'h00, 5'd1, 4'd1, 0);
        tbl[3]  = mk(1, 0, 8'h00, 0,  0, 1, 8'hA5, 5'd1, 4'd1, 0);
        tbl[4]  = mk(1, 0, 8'h00, 1,  0, 1, 8'hA5, 5'd1, 4'd1, 0);
        tbl[5]  = mk(1, 0, 8'h00, 0,  1, 0, 8'h00, 5'd0, 4'd1, 0);
        // normal mode: three words, four reads
        tbl[6]  = mk(0, 1, 8'h11, 0,  1, 0, 8'h00, 5'd0, 4'd0, 0);
        tbl[7]  = mk(0, 1, 8'h22, 0,  0, 0, 8'h00, 5'd1, 4'd0, 0);
        tbl[8]  = mk(0, 1, 8'h33, 0,  0, 0, 8'h00, 5'd2, 4'd0, 0);
        tbl[9]  = mk(0, 0, 8'h00, 1,  0, 0, 8'h00, 5'd3, 4'd0, 1);
        tbl[10] = mk(0, 0, 8'h00, 1,  0, 1, 8'h11, 5'd2, 4'd1, 1);
        tbl[11] = mk(0, 0, 8'h00, 1,  0, 1, 8'h22, 5'd1, 4'd2, 1);
        tbl[12] = mk(0, 0, 8'h00, 1,  1, 1, 8'h33, 5'd0, 4'd3, 0);
        tbl[13] = mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 5'd0, 4'd3, 0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst0.empty", 32'(if0.empty), 32'd1);
        chk("rst0.qv",    32'(if0.qv),    32'd0);
        chk("rst0.mr",    32'(if0.mr),    32'd0);
        chk("rst0.rcnt",  32'(if0.rcnt),  32'd0);
        chk("rst1.q",     32'(if1.q),     32'd0);
        tick();

        for (int i = 0; i < int'(NV); i++) begin
            we1 = tbl[i].sel & tbl[i].we;
            we0 = !tbl[i].sel & tbl[i].we;
            wd1 = tbl[i].wd;
            wd0 = tbl[i].wd;
            if1.re = tbl[i].sel & tbl[i].re;
            if0.re = !tbl[i].sel & tbl[i].re;
            @(negedge clk);
            if (tbl[i].sel) begin
                chk($sformatf("v%0d.empty", i), 32'(if1.empty), 32'(tbl[i].e_empty));
                chk($sformatf("v%0d.qv", i),    32'(if1.qv),    32'(tbl[i].e_qv));
                if (tbl[i].e_qv) chk($sformatf("v%0d.q", i), 32'(if1.q), 32'(tbl[i].e_q));
                chk($sformatf("v%0d.rcnt", i),  32'(if1.rcnt),  32'(tbl[i].e_rcnt));
                chk($sformatf("v%0d.r_pt", i),  32'(if1.r_pt),  32'(tbl[i].e_rpt));
                chk($sformatf("v%0d.mr", i),    32'(if1.mr),    32'(tbl[i].e_mr));
            end else begin
                chk($sformatf("v%0d.empty", i), 32'(if0.empty), 32'(tbl[i].e_empty));
                chk($sformatf("v%0d.qv", i),    32'(if0.qv),    32'(tbl[i].e_qv));
                if (tbl[i].e_qv) chk($sformatf("v%0d.q", i), 32'(if0.q), 32'(tbl[i].e_q));
                chk($sformatf("v%0d.rcnt", i),  32'(if0.rcnt),  32'(tbl[i].e_rcnt));
                chk($sformatf("v%0d.r_pt", i),  32'(if0.r_pt),  32'(tbl[i].e_rpt));
                chk($sformatf("v%0d.mr", i),    32'(if0.mr),    32'(tbl[i].e_mr));
            end
            tick();
        end
        clear_in();

        // show-ahead: fill RAM plus two prefetched slots, then drain back-to-back
        do_reset();
        wi1 = 0;
        for (int c = 0; c < 40 && wi1 < 10; c++) begin
            d1 = if1.w_pt - if1.r_pt;
            we1 = (d1 != 4'd8);
            wd1 = 8'(wi1);
            tick();
            if (we1) wi1++;
        end
        we1 = 1'b0;
        chk("fill.count", 32'(wi1), 32'd10);
        repeat (4) tick();
        @(negedge clk);
        chk("fill.rcnt",  32'(if1.rcnt),  32'd10);
        chk("fill.mr",    32'(if1.mr),    32'd0);
        chk("fill.r_pt",  32'(if1.r_pt),  32'd2);
        chk("fill.q",     32'(if1.q),     32'd0);
        tick();
        if1.re = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("drain%0d.qv", k), 32'(if1.qv), 32'd1);
            chk($sformatf("drain%0d.q", k),  32'(if1.q),  32'(k));
            tick();
        end
        @(negedge clk);
        chk("drain.empty", 32'(if1.empty), 32'd1);
        chk("drain.rcnt",  32'(if1.rcnt),  32'd0);
        tick();
        clear_in();

        // show-ahead backpressure: 5 words held, buffer full, issue stops
        do_reset();
        for (int k = 0; k < 5; k++) begin
            we1 = 1'b1;
            wd1 = 8'(8'h40 + k);
            tick();
        end
        we1 = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("bp.mr",   32'(if1.mr),   32'd0);
        chk("bp.rcnt", 32'(if1.rcnt), 32'd5);
        chk("bp.r_pt", 32'(if1.r_pt), 32'd2);
        tick();
        if1.re = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d.qv", k), 32'(if1.qv), 32'd1);
            chk($sformatf("bp%0d.q", k),  32'(if1.q),  32'(8'h40 + k));
            tick();
        end
        @(negedge clk);
        chk("bp.empty", 32'(if1.empty), 32'd1);
        tick();
        clear_in();

        // both modes: 20 words with concurrent traffic across pointer wrap
        do_reset();
        wi0 = 0; wi1 = 0; ri0 = 0; ri1 = 0;
        for (int c = 0; c < 300 && (ri0 < 20 || ri1 < 20); c++) begin
            d0 = if0.w_pt - if0.r_pt;
            d1 = if1.w_pt - if1.r_pt;
            we0 = (c % 4 != 3) && (wi0 < 20) && (d0 != 4'd8);
            we1 = (c % 4 != 3) && (wi1 < 20) && (d1 != 4'd8);
            wd0 = 8'(wi0 * 7 + 3);
            wd1 = 8'(wi1 * 7 + 3);
            re = (c % 5 != 4);
            if0.re = re;
            if1.re = re;
            @(negedge clk);
            if (if0.qv) begin
                exp_q = 8'(ri0 * 7 + 3);
                chk($sformatf("wrap0.q%0d", ri0), 32'(if0.q), (ri0 < 20) ? 32'(exp_q) : 32'hDEAD);
                ri0++;
            end
            if (if1.re && if1.qv) begin
                exp_q = 8'(ri1 * 7 + 3);
                chk($sformatf("wrap1.q%0d", ri1), 32'(if1.q), (ri1 < 20) ? 32'(exp_q) : 32'hDEAD);
                ri1++;
            end
            tick();
            if (we0) wi0++;
            if (we1) wi1++;
        end
        clear_in();
        chk("wrap0.count", 32'(ri0), 32'd20);
        chk("wrap1.count", 32'(ri1), 32'd20);
        @(negedge clk);
        chk("wrap0.r_pt",  32'(if0.r_pt),  32'd4);
        chk("wrap1.r_pt",  32'(if1.r_pt),  32'd4);
        chk("wrap0.empty", 32'(if0.empty), 32'd1);
        chk("wrap1.empty", 32'(if1.empty), 32'd1);
        chk("wrap1.rcnt",  32'(if1.rcnt),  32'd0);
        tick();

        // reset with a RAM read in flight and a word buffered
        do_reset();
        for (int k = 0; k < 3; k++) begin
            we1 = 1'b1;
            wd1 = 8'(8'hC0 + k);
            tick();
        end
        wd1 = 8'hC3;
        rst = 1'b1;
        @(negedge clk);
        chk("mid.qv",   32'(if1.qv),   32'd1);
        chk("mid.q",    32'(if1.q),    32'hC0);
        chk("mid.rcnt", 32'(if1.rcnt), 32'd3);
        tick();
        rst = 1'b0;
        we1 = 1'b0;
        @(negedge clk);
        chk("rst.r_pt",  32'(if1.r_pt),  32'd0);
        chk("rst.empty", 32'(if1.empty), 32'd1);
        chk("rst.qv",    32'(if1.qv),    32'd0);
        chk("rst.mr",    32'(if1.mr),    32'd0);
        chk("rst.rcnt",  32'(if1.rcnt),  32'd0);
        tick();
        we1 = 1'b1;
        wd1 = 8'h77;
        tick();
        we1 = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("post.q",    32'(if1.q),    32'h77);
        chk("post.qv",   32'(if1.qv),   32'd1);
        chk("post.rcnt", 32'(if1.rcnt), 32'd1);
        tick();

        chk("mr_guard", 32'(mr_viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
